// File: rtl/mic3_sample_ctrl.sv
// mic3_sample_ctrl: paced MIC3 read sequencer with timeout watchdog, FWFT sample FIFO and sticky status flags
module mic3_sample_ctrl #(
    parameter int SAMPLE_DIV = 2272,
    parameter int FIFO_AW    = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clr_status,
    output logic               mic_read,
    input  logic [11:0]        mic_audio,
    input  logic               mic_new_data,
    output logic [11:0]        smp_data,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               busy,
    output logic               ovf_flag,
    output logic               miss_flag,
    output logic               tout_flag
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, STORE} state_t;
    state_t             r_state, w_next;
    logic [15:0]        r_tick, r_tcnt;
    logic [11:0]        r_cap;
    logic [11:0]        r_mem [2**FIFO_AW];
    logic [FIFO_AW:0]   r_wr, r_rd;
    logic               r_ovf, r_miss, r_tout;
    logic               w_tick, w_capture, w_tout, w_empty, w_full, w_pop, w_push, w_drop;

    assign w_tick    = enable && r_tick == 16'(SAMPLE_DIV - 1);
    // new_data takes priority over an expiring timeout in the same cycle
    assign w_capture = r_state == WAIT && mic_new_data;
    assign w_tout    = r_state == WAIT && !mic_new_data && r_tcnt == 16'(TIMEOUT - 1);
    assign w_empty   = r_wr == r_rd;
    assign w_full    = r_wr[FIFO_AW] != r_rd[FIFO_AW] && r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0];
    assign w_pop     = smp_ready && !w_empty;
    assign w_push    = r_state == STORE && (!w_full || w_pop);
    assign w_drop    = r_state == STORE && !w_push;

    always_comb begin
        w_next   = r_state == IDLE ? (w_tick ? REQ : IDLE) :
                   r_state == REQ  ? WAIT :
                   r_state == WAIT ? (w_capture ? STORE : w_tout ? IDLE : WAIT) : IDLE;
        mic_read = r_state == REQ;
        busy     = r_state != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_tcnt  <= '0;
            r_cap   <= '0;
        end else begin
            r_state <= w_next;
            r_tick  <= (!enable || w_tick) ? '0 : r_tick + 16'd1;
            r_tcnt  <= (r_state == WAIT && !w_capture && !w_tout) ? r_tcnt + 16'd1 : '0;
            r_cap   <= w_capture ? mic_audio : r_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[FIFO_AW-1:0]] <= r_cap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_ovf  <= 1'b0;
            r_miss <= 1'b0;
            r_tout <= 1'b0;
        end else begin
            r_wr   <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd   <= w_pop ? r_rd + 1'b1 : r_rd;
            r_ovf  <= w_drop | (r_ovf & ~clr_status);
            r_miss <= (w_tick && r_state != IDLE) | (r_miss & ~clr_status);
            r_tout <= w_tout | (r_tout & ~clr_status);
        end
    end

    assign smp_valid  = !w_empty;
    assign smp_data   = w_empty ? '0 : r_mem[r_rd[FIFO_AW-1:0]];
    assign fifo_level = r_wr - r_rd;
    assign ovf_flag   = r_ovf;
    assign miss_flag  = r_miss;
    assign tout_flag  = r_tout;
endmodule

// File: tb/tb_mic3_sample_ctrl.sv
// tb_mic3_sample_ctrl: randomized bench with reader model and queue-level FIFO/flag reference
module tb_mic3_sample_ctrl;
    localparam int DIV = 100;
    localparam int TO  = 40;

    logic clk = 0, rst = 1, enable = 0, clr = 0, ready = 0, en1 = 0;
    logic mic_read, nd, svalid, busy, ovf, miss, tout;
    logic [11:0] audio, sdata;
    logic [4:0] level;
    logic rd1, nd1, sv1, busy1, ovf1, miss1, tout1;
    logic [11:0] au1, sd1;
    logic [4:0] lv1;

    mic3_sample_ctrl #(.SAMPLE_DIV(DIV), .FIFO_AW(4), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_status(clr), .mic_read(mic_read),
        .mic_audio(audio), .mic_new_data(nd), .smp_data(sdata), .smp_valid(svalid),
        .smp_ready(ready), .fifo_level(level), .busy(busy), .ovf_flag(ovf),
        .miss_flag(miss), .tout_flag(tout));

    mic3_sample_ctrl #(.SAMPLE_DIV(DIV), .FIFO_AW(4), .TIMEOUT(255)) u_slow (
        .clk(clk), .rst(rst), .enable(en1), .clr_status(1'b0), .mic_read(rd1),
        .mic_audio(au1), .mic_new_data(nd1), .smp_data(sd1), .smp_valid(sv1),
        .smp_ready(1'b1), .fifo_level(lv1), .busy(busy1), .ovf_flag(ovf1),
        .miss_flag(miss1), .tout_flag(tout1));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit answer = 1, lat_rand = 0, per_on = 0;
    int lat = 30;

    logic [11:0] q[$], popq[$], sent1[$], got1[$];
    logic [11:0] st_val;
    bit m_ovf, m_tout, st_pend, outst, pop, oset, tset;
    int tw, rcnt, gen, cyc_n, last_rd, rd_total, ans_total, pop_obs, sz, rc1;

    // Reference: reader answers a fixed or random number of cycles after mic_read;
    // the FIFO is a plain queue updated once per clock.
    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_tout = 0; st_pend = 0; outst = 0; tw = 0; rcnt = 0;
            nd = 0; audio = 0; last_rd = -1;
            chk("rst_read", mic_read, 0);
            chk("rst_level", level, 0);
            chk("rst_valid", svalid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_flags", {ovf, miss, tout}, 0);
        end else begin
            chk("level", level, q.size());
            chk("valid", svalid, q.size() != 0);
            if (q.size() != 0) chk("data", sdata, q[0]);
            chk("ovf", ovf, m_ovf);
            chk("tout", tout, m_tout);
            chk("miss", miss, 0);
            if (svalid && ready) begin
                pop_obs++;
                popq.push_back(sdata);
            end
            oset = 0; tset = 0;
            sz = q.size();
            pop = sz != 0 && ready;
            if (pop) void'(q.pop_front());
            if (st_pend) begin
                if (sz < 16 || pop) q.push_back(st_val);
                else oset = 1;
            end
            st_pend = 0;
            nd = 0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    nd = 1;
                    audio = gen == 0 ? 12'hA5C : gen == 1 ? 12'h3F0 : 12'($urandom);
                    gen++;
                    ans_total++;
                end
            end
            if (outst) begin
                tw--;
                if (nd) begin
                    st_pend = 1; st_val = audio; outst = 0;
                end else if (tw == 0) begin
                    tset = 1; outst = 0;
                end
            end
            if (mic_read) begin
                outst = 1; tw = TO; rd_total++;
                if (answer) rcnt = lat_rand ? $urandom_range(5, TO) : lat;
                if (per_on && last_rd >= 0) chk("period", cyc_n - last_rd, DIV);
                last_rd = per_on ? cyc_n : -1;
            end else if (!per_on) last_rd = -1;
            m_ovf  = oset | (m_ovf & !clr);
            m_tout = tset | (m_tout & !clr);
        end
    end

    always @(negedge clk) begin
        nd1 = 0;
        if (rst) begin
            rc1 = 0; au1 = 0;
        end else begin
            if (rc1 > 0) begin
                rc1--;
                if (rc1 == 0) begin
                    nd1 = 1;
                    au1 = 12'($urandom);
                    sent1.push_back(au1);
                end
            end
            if (rd1) rc1 = 120;
            if (sv1) got1.push_back(sd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_clr();
        clr = 1;
        cyc(1);
        clr = 0;
    endtask

    task automatic wait_rd(input string tag);
        int r = rd_total;
        int n = 0;
        while (rd_total == r && n < 300) begin
            cyc(1);
            n++;
        end
        chk(tag, rd_total != r, 1);
    endtask

    initial begin
        int p, r, a, n;
        cyc(3);
        chk("rst_sdata", sdata, 0);
        rst = 0;
        cyc(2);
        ready = 1; answer = 1; lat = 30; enable = 1; per_on = 1;
        cyc(1050);
        chk("steady_reads", rd_total, 10);
        chk("steady_pops", pop_obs, 10);
        chk("first", popq[0], 12'hA5C);
        chk("second", popq[1], 12'h3F0);
        lat_rand = 1;
        repeat (600) begin
            ready = 1'($urandom_range(0, 1));
            cyc(1);
        end
        ready = 1; lat_rand = 0;
        cyc(200);
        ready = 0;
        cyc(2000);
        chk("ovf_level", level, 16);
        chk("ovf_flag", ovf, 1);
        ready = 1;
        cyc(150);
        pulse_clr();
        chk("ovf_clr", ovf, 0);
        ready = 0;
        n = 0;
        while (level != 16 && n < 2500) begin
            cyc(1);
            n++;
        end
        chk("fill_level", level, 16);
        chk("fill_ovf", ovf, 0);
        a = ans_total; n = 0;
        while (ans_total == a && n < 200) begin
            cyc(1);
            n++;
        end
        ready = 1;
        cyc(1);
        ready = 0;
        chk("fullpop_level", level, 16);
        chk("fullpop_ovf", ovf, 0);
        ready = 1;
        cyc(100);
        answer = 0;
        wait_rd("tmo_rd");
        cyc(45);
        chk("tmo_flag", tout, 1);
        chk("tmo_busy", busy, 0);
        wait_rd("tmo_retry");
        pulse_clr();
        chk("tmo_clr", tout, 0);
        cyc(50);
        pulse_clr();
        answer = 1; lat = 40; p = pop_obs;
        wait_rd("b40_rd");
        cyc(50);
        chk("b40_tout", tout, 0);
        chk("b40_pop", pop_obs - p, 1);
        lat = 41; p = pop_obs;
        wait_rd("b41_rd");
        cyc(50);
        chk("b41_tout", tout, 1);
        chk("b41_pop", pop_obs - p, 0);
        pulse_clr();
        lat = 30; ready = 0; answer = 0;
        wait_rd("pre_tmo_rd");
        cyc(45);
        answer = 1;
        wait_rd("pre_rd1");
        cyc(40);
        wait_rd("pre_rd2");
        cyc(10);
        chk("pre_busy", busy, 1);
        chk("pre_tout", tout, 1);
        chk("pre_level", level != 0, 1);
        rst = 1;
        #1;
        chk("rst_level_async", level, 0);
        chk("rst_busy_async", busy, 0);
        cyc(3);
        rst = 0;
        chk("post_level", level, 0);
        chk("post_tout", tout, 0);
        chk("post_busy", busy, 0);
        cyc(60);
        chk("stale", level, 0);
        ready = 1; per_on = 0;
        wait_rd("en_rd");
        p = pop_obs; r = rd_total;
        cyc(5);
        enable = 0;
        cyc(300);
        chk("en_pop", pop_obs - p, 1);
        chk("en_reads", rd_total - r, 0);
        chk("en_busy", busy, 0);
        en1 = 1;
        cyc(150);
        chk("miss_early", miss1, 0);
        cyc(100);
        chk("miss_set", miss1, 1);
        cyc(700);
        en1 = 0;
        cyc(200);
        chk("miss_sent", sent1.size(), 5);
        chk("miss_got", got1.size(), sent1.size());
        for (int i = 0; i < got1.size() && i < sent1.size(); i++) chk("miss_data", got1[i], sent1[i]);
        chk("miss_tout", tout1, 0);
        chk("miss_ovf", ovf1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
